// File: rtl/memshare_rqst_sched_pkg.sv
// Shared types and helpers for the memShare request scheduler.
// Optional feature macro used by this slice: MEMSHARE_RR_PRIO_EN (rotating priority).
package memshare_sched_pkg;

    typedef enum logic [0:0] {
        IDLE,
        DRAIN
    } state_e;

    localparam logic NOSKID = 1'b0;
    localparam logic SKID   = 1'b1;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/memshare_rqst_sched_if.sv
// Request-flag / grant bundle between the skid buffer side and the scheduler.
interface memshare_rqst_sched_if #(
    parameter int unsigned SHARE_GROUP_SIZE = 5,
    parameter int unsigned SERVE_PER_CYCLE  = 2
);
    localparam int unsigned CNT_W = $clog2(SERVE_PER_CYCLE + 1);

    logic [SHARE_GROUP_SIZE-1:0] rqst_flag_i;
    logic                        rqst_valid_i;
    logic [SHARE_GROUP_SIZE-1:0] grant_o;
    logic                        grant_valid_o;
    logic [CNT_W-1:0]            grant_cnt_o;
    logic                        update_mask_o;
    logic                        skid_sel_o;
    logic                        busy_o;

    modport master (
        output rqst_flag_i, rqst_valid_i,
        input  grant_o, grant_valid_o, grant_cnt_o, update_mask_o, skid_sel_o, busy_o
    );

    modport slave (
        input  rqst_flag_i, rqst_valid_i,
        output grant_o, grant_valid_o, grant_cnt_o, update_mask_o, skid_sel_o, busy_o
    );

endinterface

// File: rtl/memshare_rqst_sched_prio_pick.sv
// Combinational pick of up to SERVE_PER_CYCLE set flags, searching upward from start_i
// and wrapping modulo SHARE_GROUP_SIZE.
module memshare_prio_pick #(
    parameter int unsigned SHARE_GROUP_SIZE = 5,
    parameter int unsigned SERVE_PER_CYCLE  = 2
) (
    input  logic [SHARE_GROUP_SIZE-1:0]                                       flags_i,
    input  logic [((SHARE_GROUP_SIZE > 1) ? $clog2(SHARE_GROUP_SIZE) : 1)-1:0] start_i,
    output logic [SHARE_GROUP_SIZE-1:0]                                       pick_o,
    output logic [SHARE_GROUP_SIZE-1:0]                                       rem_o
);
    localparam int unsigned IDX_W = (SHARE_GROUP_SIZE > 1) ? $clog2(SHARE_GROUP_SIZE) : 1;

    logic [IDX_W-1:0] idx;
    int unsigned      cnt;

    always_comb begin
        pick_o = '0;
        cnt    = 0;
        idx    = '0;
        for (int unsigned k = 0; k < SHARE_GROUP_SIZE; k++) begin
            idx = IDX_W'((32'(start_i) + k) % SHARE_GROUP_SIZE);
            if (flags_i[idx] && (cnt < SERVE_PER_CYCLE)) begin
                pick_o[idx] = 1'b1;
                cnt         = cnt + 1;
            end
        end
        rem_o = flags_i & ~pick_o;
    end

endmodule

// File: rtl/memshare_rqst_sched.sv
// memShare request scheduler: grants up to SERVE_PER_CYCLE flags per cycle and holds the
// upstream skid buffer while residual requests drain. MEMSHARE_RR_PRIO_EN selects rotating priority.
module memshare_rqst_sched
    import memshare_sched_pkg::*;
#(
    parameter int unsigned SHARE_GROUP_SIZE = 5,
    parameter int unsigned SERVE_PER_CYCLE  = 2
) (
    input logic                  sys_clk,
    input logic                  rstn,
    memshare_rqst_sched_if.slave bus
);
    localparam int unsigned N     = SHARE_GROUP_SIZE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = $clog2(SERVE_PER_CYCLE + 1);

    if ((SERVE_PER_CYCLE < 1) || (SERVE_PER_CYCLE > SHARE_GROUP_SIZE)) begin : g_bad_cfg
        $error("memshare_rqst_sched: SERVE_PER_CYCLE out of range");
    end

    state_e           state_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     src;
    logic [N-1:0]     pick;
    logic [N-1:0]     rem;
    logic [IDX_W-1:0] start_idx;

    // Upstream is frozen during DRAIN, so only the pending set is considered there.
    always_comb begin
        src = '0;
        if (state_q == DRAIN) begin
            src = pending_q;
        end else if (bus.rqst_valid_i) begin
            src = bus.rqst_flag_i;
        end
    end

    memshare_prio_pick #(
        .SHARE_GROUP_SIZE(N),
        .SERVE_PER_CYCLE (SERVE_PER_CYCLE)
    ) u_pick (
        .flags_i(src),
        .start_i(start_idx),
        .pick_o (pick),
        .rem_o  (rem)
    );

`ifdef MEMSHARE_RR_PRIO_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] scan_idx;

    // Pointer follows the last granted index in search order.
    always_comb begin
        ptr_d    = ptr_q;
        scan_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = IDX_W'((32'(ptr_q) + k) % N);
            if (pick[scan_idx]) begin
                ptr_d = IDX_W'((32'(scan_idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_idx = ptr_q;
`else
    assign start_idx = '0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
        end else begin
            grant_q   <= pick;
            pending_q <= rem;
            case (state_q)
                IDLE:    state_q <= (rem != '0) ? DRAIN : IDLE;
                DRAIN:   state_q <= (rem == '0) ? IDLE : DRAIN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = |grant_q;
    assign bus.grant_cnt_o   = CNT_W'(popcount(32'(grant_q)));
    assign bus.update_mask_o = (state_q == DRAIN);
    assign bus.skid_sel_o    = (state_q == DRAIN) ? SKID : NOSKID;
    assign bus.busy_o        = (state_q == DRAIN);

    a_grant_limit: assert property (@(posedge sys_clk) disable iff (!rstn)
        popcount(32'(grant_q)) <= SERVE_PER_CYCLE);
    a_grant_pending_disjoint: assert property (@(posedge sys_clk) disable iff (!rstn)
        (grant_q & pending_q) == '0);

endmodule

// File: tb/tb_memshare_rqst_sched.sv
// Self-checking bench for memshare_rqst_sched: directed steps then randomized traffic
// against a queue-based reference model.
module tb_memshare_rqst_sched;
    localparam int unsigned N     = 5;
    localparam int unsigned SPC   = 2;
    localparam int unsigned CNT_W = $clog2(SPC + 1);
`ifdef MEMSHARE_RR_PRIO_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic sys_clk;
    logic rstn;

    memshare_rqst_sched_if #(.SHARE_GROUP_SIZE(N), .SERVE_PER_CYCLE(SPC)) bus ();

    memshare_rqst_sched #(
        .SHARE_GROUP_SIZE(N),
        .SERVE_PER_CYCLE (SPC)
    ) dut (
        .sys_clk(sys_clk),
        .rstn   (rstn),
        .bus    (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    int           q[$];
    int           ptr = 0;
    logic [N-1:0] exp_grant = '0;
    logic         exp_busy = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: an accepted vector becomes a queue of requestors in search order;
    // each cycle serves the next SPC entries of that queue.
    task automatic model_step(input logic v, input logic [N-1:0] f, input logic r);
        int last;
        int order;
        exp_grant = '0;
        last      = -1;
        if (r) begin
            q.delete();
            ptr = 0;
        end else begin
            if ((q.size() == 0) && v) begin
                for (int k = 0; k < N; k++) begin
                    order = (ptr + k) % N;
                    if (f[order]) q.push_back(order);
                end
            end
            for (int k = 0; (k < SPC) && (q.size() > 0); k++) begin
                last            = q.pop_front();
                exp_grant[last] = 1'b1;
            end
            if (RrEn && (last >= 0)) ptr = (last + 1) % N;
        end
        exp_busy = (q.size() != 0);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".grant"}, 16'(bus.grant_o), 16'(exp_grant));
        check({tag, ".cnt"}, 16'(bus.grant_cnt_o), 16'($countones(exp_grant)));
        check({tag, ".gvalid"}, 16'(bus.grant_valid_o), 16'(exp_grant != '0));
        check({tag, ".mask"}, 16'(bus.update_mask_o), 16'(exp_busy));
        check({tag, ".sel"}, 16'(bus.skid_sel_o), 16'(exp_busy));
        check({tag, ".busy"}, 16'(bus.busy_o), 16'(exp_busy));
    endtask

    task automatic cycle(input string tag, input logic v, input logic [N-1:0] f, input logic r);
        bus.rqst_valid_i = v;
        bus.rqst_flag_i  = f;
        rstn             = ~r;
        @(posedge sys_clk);
        #1;
        model_step(v, f, r);
        check_all(tag);
    endtask

    initial begin
        logic [N-1:0] rf;
        logic         rv;
        logic         rr;
        rstn             = 1'b0;
        bus.rqst_valid_i = 1'b0;
        bus.rqst_flag_i  = '0;

        // 1: reset, idle, reset mid-stream
        cycle("t1.rst", 1'b0, '0, 1'b1);
        cycle("t1.rst", 1'b0, '0, 1'b1);
        for (int i = 0; i < 10; i++) cycle("t1.idle", 1'b0, 5'b10101, 1'b0);
        cycle("t1.acc", 1'b1, 5'b11011, 1'b0);
        cycle("t1.midrst", 1'b1, 5'b11111, 1'b1);
        check("t1.midrst_grant", 16'(bus.grant_o), 16'h0);

        // 2: two requests fit in one cycle
        cycle("t2.a", 1'b1, 5'b00101, 1'b0);
        check("t2.const_grant", 16'(bus.grant_o), 16'h05);
        check("t2.const_cnt", 16'(bus.grant_cnt_o), 16'd2);
        cycle("t2.b", 1'b0, '0, 1'b0);

        // 3: three requests need one drain cycle
        cycle("t3.a", 1'b1, 5'b10111, 1'b0);
        cycle("t3.b", 1'b1, 5'b01000, 1'b0);
        cycle("t3.c", 1'b0, '0, 1'b0);

        // 4: full vector from a fresh pointer, inputs toggling during drain
        cycle("t4.rst", 1'b0, '0, 1'b1);
        cycle("t4.a", 1'b1, 5'b11111, 1'b0);
        check("t4.const_g1", 16'(bus.grant_o), 16'h03);
        check("t4.const_m1", 16'(bus.update_mask_o), 16'd1);
        cycle("t4.b", 1'b1, 5'b00001, 1'b0);
        check("t4.const_g2", 16'(bus.grant_o), 16'h0C);
        check("t4.const_m2", 16'(bus.update_mask_o), 16'd1);
        cycle("t4.c", 1'b0, 5'b11110, 1'b0);
        check("t4.const_g3", 16'(bus.grant_o), 16'h10);
        check("t4.const_m3", 16'(bus.update_mask_o), 16'd0);

        // 5: reset during drain drops residual requests
        cycle("t5.a", 1'b1, 5'b11111, 1'b0);
        cycle("t5.rst", 1'b1, 5'b11111, 1'b1);
        cycle("t5.idle", 1'b0, '0, 1'b0);
        check("t5.const_nogrant", 16'(bus.grant_o), 16'h0);
        cycle("t5.b", 1'b1, 5'b00001, 1'b0);
        check("t5.const_g", 16'(bus.grant_o), 16'h01);

        // 6: pointer behaviour after a partial vector; all-zero valid vector
        cycle("t6.rst", 1'b0, '0, 1'b1);
        cycle("t6.a", 1'b1, 5'b11111, 1'b0);
        cycle("t6.b", 1'b0, '0, 1'b0);
        cycle("t6.c", 1'b0, '0, 1'b0);
        cycle("t6.d", 1'b1, 5'b00011, 1'b0);
        check("t6.const_g", 16'(bus.grant_o), 16'h03);
        cycle("t6.e", 1'b1, 5'b11111, 1'b0);
        cycle("t6.f", 1'b0, '0, 1'b0);
        cycle("t6.g", 1'b0, '0, 1'b0);
        cycle("t6.zero", 1'b1, 5'b00000, 1'b0);
        check("t6.const_zero", 16'(bus.grant_valid_o), 16'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rf = N'($urandom);
            rr = ($urandom_range(0, 49) == 0);
            cycle("rnd", rv, rf, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memshare_rqst_sched.md
Name: memshare_rqst_sched

Overview:
Consumer side of the request-flag skid-buffer interface inside the access_rqst_gen.memShare_sched datapath. Accepts one share-group request-flag vector per cycle and issues at most SERVE_PER_CYCLE grants per cycle to the shared memory port. When a vector is oversubscribed, it stalls the upstream skid buffer by driving the buffer's update-mask and skid-select controls, then drains the residual requests over the following cycles.

Parameters:
SHARE_GROUP_SIZE, 5, number of requestors in one share group (N)
SERVE_PER_CYCLE, 2, maximum grants issued per cycle; legal range 1..SHARE_GROUP_SIZE
IDX_W, $clog2(SHARE_GROUP_SIZE), derived localparam, width of the rotating-priority pointer

Ports:
sys_clk  in  1  clock
rstn  in  1  reset; synchronous, active-low; clock sys_clk
rqst_flag_i  in  N  request flags from skid-buffer output
rqst_valid_i  in  1  rqst_flag_i is valid this cycle
grant_o  out  N  one bit per granted requestor (registered)
grant_valid_o  out  1  grant_o is non-zero this cycle
grant_cnt_o  out  $clog2(SERVE_PER_CYCLE+1)  popcount of grant_o
update_mask_o  out  1  to skid buffer: hold contents, active HIGH
skid_sel_o  out  1  to skid buffer: select buffered flags (1=SKID, 0=NOSKID)
busy_o  out  1  high while residual requests are pending

Behaviour:
- Reset: all outputs 0; pending register 0; state IDLE; RR pointer 0.
- State is an enum {IDLE, DRAIN}. Pending is an N-bit register.
- IDLE:
  - If rqst_valid_i is high, pick up to SERVE_PER_CYCLE set bits of rqst_flag_i using the priority pick below.
  - Picked bits load into grant_o at the next edge, so latency is 1 cycle from acceptance.
  - Unpicked set bits load into pending.
  - If pending would be non-zero, go to DRAIN; otherwise stay in IDLE.
- DRAIN:
  - rqst_valid_i and rqst_flag_i are ignored, because the upstream is held.
  - Pick up to SERVE_PER_CYCLE bits from pending into grant_o and clear them from pending.
  - Return to IDLE at the edge where pending becomes 0.
- update_mask_o = skid_sel_o = busy_o = (state == DRAIN); all three are decoded directly from the state register.
- For a vector with k set bits, the mask is high for ceil(k/SERVE_PER_CYCLE)-1 cycles.
- New input is accepted on the first IDLE cycle after DRAIN.
- grant_o is 0 in any cycle with no pick; grant_valid_o = |grant_o; grant_cnt_o = popcount(grant_o).
- Default priority pick: fixed priority, lowest index first.
- Boundaries:
  - rqst_valid_i high with all-zero flags: no grant, stay IDLE.
  - SERVE_PER_CYCLE >= N: DRAIN is never entered.
  - rstn low mid-DRAIN: pending cleared, IDLE next cycle, mask/sel drop that cycle; no grant is issued for the residual requests.
  - A grant never contains a bit absent from the accepted vector.
  - No bit is granted twice per accepted vector.
- Assertions: SERVE_PER_CYCLE in range (elaboration check); popcount(grant_o) <= SERVE_PER_CYCLE; grant_o & pending == 0.

Optional Feature:
MEMSHARE_RR_PRIO_EN
- Defined: rotating priority.
  - The search starts at the RR pointer and wraps modulo N.
  - After any non-zero grant, the pointer loads (highest-searched granted index + 1) mod N.
  - The pointer is unchanged on cycles with no grant; reset value is 0.
- Undefined: fixed lowest-index priority; pointer register not instantiated.

Decomposition:
- Package memshare_sched_pkg:
  - state enum typedef (IDLE, DRAIN)
  - NOSKID/SKID constants
  - popcount function
- One sub-module, memshare_prio_pick:
  - combinational, parameterised N/SERVE_PER_CYCLE
  - inputs: flags, start index
  - outputs: picked vector, remainder vector
  - start index tied to 0 when the macro is off

Test Plan (N=5, SERVE_PER_CYCLE=2):
1. Reset then idle: all outputs 0 for 10 cycles; assert rstn low mid-stream -> outputs 0 on the following cycle.
2. rqst_flag_i=5'b00101, valid -> next cycle grant_o=00101, cnt=2, update_mask_o=0 throughout.
3. rqst_flag_i=5'b10111 -> cycle+1 grant 00011 with mask/sel/busy=1; cycle+2 grant 10100 with mask=0; IDLE after.
4. rqst_flag_i=5'b11111 -> grants 00011, 01100, 10000 on consecutive cycles; mask high exactly 2 cycles; changing inputs during DRAIN are ignored.
5. In DRAIN after 11111, pulse rstn low -> no further grants, pending=0, mask=0; then 5'b00001 accepted -> grant 00001.
6. With MEMSHARE_RR_PRIO_EN: 11111 gives 00011/01100/10000; then 00011 -> grant 00011, pointer 2; then 11111 -> first grant 01100. Also valid with 00000 -> no grant.
